apb_bus_arbiter: RTL
====================

Name: apb_bus_arbiter

Overview:
- Shares the core's single APB-like external bus between two requesters: the fetch unit (read-only) and the load/store unit (read/write).
- Sequences each transfer through setup and access phases, waits for slave ready, and returns read data plus an error flag to the winning requester.
- Default priority goes to load/store. A starvation counter guarantees fetch progress.
- An access-phase timeout prevents a dead slave from hanging the pipeline.

Parameters:
STARVE_LIMIT, 4, consecutive load/store grants allowed while fetch waits before fetch is forced to win (>=1)
TIMEOUT, 256, maximum access-phase cycles before abort; 0 disables timeout
CNT_W, 9, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_req  in  1  fetch transfer request; held with fetch_addr stable until fetch_done
fetch_addr  in  32  fetch address
fetch_done  out  1  one-cycle completion pulse to fetch
lsu_req  in  1  load/store request; held with fields stable until lsu_done
lsu_addr  in  32  load/store address
lsu_write  in  1  1 = write, 0 = read
lsu_wdata  in  32  write data
lsu_done  out  1  one-cycle completion pulse to load/store
resp_rdata  out  32  read data, valid while either done is high
resp_err  out  1  timeout error, valid while either done is high
addr  out  32  bus address
select  out  1  bus select
enable  out  1  bus access-phase enable
write  out  1  bus write
wdata  out  32  bus write data
rdata  in  32  bus read data
ready  in  1  slave ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE. select, enable, write, fetch_done, lsu_done and resp_err are 0. addr, wdata and resp_rdata are 0. Both counters are 0.
- Output timing: all outputs are registered. No combinational path from any input to any output.
- FSM IDLE:
  - Arbitrate in this cycle.
  - If any request is present: latch the winner (owner), addr, write and wdata (write and wdata forced to 0 for fetch), then go to SETUP.
  - Otherwise stay in IDLE.
- FSM SETUP: select=1, enable=0. Always go to ACCESS next cycle. Clear the timeout counter.
- FSM ACCESS:
  - select=1, enable=1.
  - If ready=1: capture rdata (write transfers capture 0), set resp_err=0, go to RESP.
  - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1: resp_rdata=0, resp_err=1, go to RESP.
  - Else increment the counter.
- FSM RESP:
  - select=0, enable=0.
  - The owner's done pulse is 1 for exactly this cycle.
  - Go to IDLE.
  - Requests are not sampled in RESP, so a held req cannot cause a stale re-grant.
- Latency: with ready in the first access cycle, a request seen in IDLE at cycle t gives SETUP at t+1, ACCESS at t+2, done at t+3. Minimum 4 cycles between back-to-back transfer starts.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting: lsu wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt update:
  - Increments, saturating at STARVE_LIMIT, when lsu is granted while fetch_req=1.
  - Clears when fetch is granted.
  - Otherwise holds.
- Request withdrawal: a requester may drop req before it is granted (e.g. a fetch flush); it is then not granted. Once SETUP is entered the transfer is committed and completes or times out even if req drops. The done pulse is still issued.
- Non-owner: done is never asserted to the requester that did not win.
- Held fields: addr, write and wdata stay constant from SETUP through ACCESS.
- Reset mid-transfer: the bus drops immediately (select and enable go to 0 asynchronously). No done pulse is issued.
- Ready outside ACCESS: ready is ignored.

Test Plan:
- Single lsu write, addr=0x8000_0010, wdata=0xDEAD_BEEF, ready high on first access cycle -> SETUP with select=1, enable=0; ACCESS with write=1; lsu_done at t+3, resp_err=0, fetch_done never asserted.
- Single fetch read at 0x0000_0100, ready after 3 wait cycles with rdata=0x0000_0013 -> enable high for 4 cycles; fetch_done with resp_rdata=0x13; write=0 throughout.
- fetch_req and lsu_req held continuously, STARVE_LIMIT=4, lsu re-requesting after every done -> grant order L,L,L,L,F,L,L,L,L,F.
- TIMEOUT=8, ready never asserted -> exactly 8 ACCESS cycles, then owner done with resp_err=1 and resp_rdata=0; next transfer proceeds normally.
- fetch_req asserted then dropped while an lsu transfer is in progress; fetch_req dropped before the next IDLE -> no fetch grant, no fetch_done. In a separate run, rst asserted during ACCESS -> select=0 and enable=0 immediately, no done pulse, FSM in IDLE after reset.

Source files
------------

// File: rtl/apb_bus_arbiter.sv
// Two-master arbiter for the core's single APB-like bus: fetch (read-only) and load/store.
// Load/store wins by default; a starvation counter forces fetch through; access phase can time out.
module apb_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 256,
   parameter int CNT_W        = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_done,
   input  logic        lsu_req,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_write,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_done,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] addr,
   output logic        select,
   output logic        enable,
   output logic        write,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        ready
);

   localparam int                SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit                TO_EN      = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state_q, state_d;
   logic             owner_fetch_q, owner_fetch_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             write_q, write_d;
   logic             select_q, select_d;
   logic             enable_q, enable_d;
   logic             fetch_done_q, fetch_done_d;
   logic             lsu_done_q, lsu_done_d;
   logic             err_q, err_d;
   logic             grant_fetch;
   logic             finish_xfer;

   // Fetch wins when it is alone, or when load/store has had its quota of back-to-back grants.
   always_comb begin
      grant_fetch = fetch_req && (!lsu_req || (starve_q == STARVE_MAX));
   end

   always_comb begin
      state_d       = state_q;
      owner_fetch_d = owner_fetch_q;
      starve_d      = starve_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      write_d       = write_q;
      select_d      = select_q;
      enable_d      = enable_q;
      fetch_done_d  = 1'b0;
      lsu_done_d    = 1'b0;
      err_d         = err_q;
      finish_xfer   = 1'b0;

      case (state_q)
         IDLE: begin
            if (fetch_req || lsu_req) begin
               owner_fetch_d = grant_fetch;
               addr_d        = grant_fetch ? fetch_addr : lsu_addr;
               write_d       = !grant_fetch && lsu_write;
               wdata_d       = grant_fetch ? 32'h0 : lsu_wdata;
               if (grant_fetch) begin
                  starve_d = '0;
               end else if (fetch_req && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + SW'(1);
               end
               select_d = 1'b1;
               enable_d = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            enable_d = 1'b1;
            cnt_d    = '0;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (ready) begin
               rdata_d     = write_q ? 32'h0 : rdata;
               err_d       = 1'b0;
               finish_xfer = 1'b1;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               rdata_d     = 32'h0;
               err_d       = 1'b1;
               finish_xfer = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (finish_xfer) begin
               select_d     = 1'b0;
               enable_d     = 1'b0;
               fetch_done_d = owner_fetch_q;
               lsu_done_d   = !owner_fetch_q;
               state_d      = RESP;
            end
         end
         RESP: begin
            // Requests are deliberately not looked at here; a still-held req is re-arbitrated in IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            select_d = 1'b0;
            enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_fetch_q <= 1'b0;
         starve_q      <= '0;
         cnt_q         <= '0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         rdata_q       <= 32'h0;
         write_q       <= 1'b0;
         select_q      <= 1'b0;
         enable_q      <= 1'b0;
         fetch_done_q  <= 1'b0;
         lsu_done_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_fetch_q <= owner_fetch_d;
         starve_q      <= starve_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         write_q       <= write_d;
         select_q      <= select_d;
         enable_q      <= enable_d;
         fetch_done_q  <= fetch_done_d;
         lsu_done_q    <= lsu_done_d;
         err_q         <= err_d;
      end
   end

   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign write      = write_q;
   assign select     = select_q;
   assign enable     = enable_q;
   assign fetch_done = fetch_done_q;
   assign lsu_done   = lsu_done_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
